// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states, iteration count and the sign-fixup helpers.
package muldiv_pkg;

   localparam int unsigned MULDIV_ITERS = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_COMMIT
   } state_t;

   // Two's-complement negate when neg is set; used to restore signs after
   // the datapath has worked on magnitudes.
   function automatic logic [63:0] sign_fix64(input logic [63:0] v, input logic neg);
      return neg ? (~v + 64'd1) : v;
   endfunction

   function automatic logic [31:0] sign_fix32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module div_step (
   input  logic [31:0] i_rem,
   input  logic        i_dvd_bit,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_rem,
   output logic        o_qbit
);

   logic [32:0] w_shift;
   logic [31:0] w_sub;
   logic        w_ge;

   // The shifted remainder can need 33 bits, but whenever the subtraction
   // is taken the difference is below the divisor, so 32 bits suffice.
   always_comb begin
      w_shift = {i_rem, i_dvd_bit};
      w_ge    = (w_shift >= {1'b0, i_divisor});
      w_sub   = w_shift[31:0] - i_divisor;
      o_qbit  = w_ge;
      o_rem   = w_ge ? w_sub : w_shift[31:0];
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner with a 32-step shift-add multiplier and restoring divider.
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU use a single-cycle
// combinational multiply instead of the iterative one.
module hilo_muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   input  logic        hilo_rd,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic        stall
);

   localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERS - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [63:0] r_acc;
   logic [4:0]  r_cnt;
   logic        r_sa;
   logic        r_sb;
   logic        r_is_div;
   logic        r_done;
   logic        r_dbz;

   logic        w_accept;
   logic        w_signed;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic        w_last;
   logic [31:0] w_rem_nxt;
   logic        w_qbit;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_dvd;

`ifndef MULDIV_FAST_MULT_EN
   logic [32:0] w_mul_sum;
`endif

   // Operand conditioning: signed ops work on magnitudes, signs kept aside.
   always_comb begin
      w_accept = (r_state == ST_IDLE) && start && !flush;
      w_signed = ~op[0];
      w_neg_a  = w_signed & rs_val[31];
      w_neg_b  = w_signed & rt_val[31];
      w_mag_a  = sign_fix32(rs_val, w_neg_a);
      w_mag_b  = sign_fix32(rt_val, w_neg_b);
      w_last   = (r_cnt == LAST_ITER);
   end

   // r_acc doubles as {partial remainder, dividend/quotient shift register}.
   div_step u_div_step (
      .i_rem     (r_acc[63:32]),
      .i_dvd_bit (r_acc[31]),
      .i_divisor (r_b),
      .o_rem     (w_rem_nxt),
      .o_qbit    (w_qbit)
   );

`ifndef MULDIV_FAST_MULT_EN
   // Shift-add step: r_acc holds {partial product, remaining multiplier}.
   always_comb begin
      w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
   end
`endif

   // Commit-time sign restoration of product, quotient and remainder.
   always_comb begin
      w_prod = sign_fix64(r_acc, r_sa ^ r_sb);
      w_quo  = sign_fix32(r_acc[31:0], r_sa ^ r_sb);
      w_rem  = sign_fix32(r_acc[63:32], r_sa);
      w_dvd  = sign_fix32(r_a, r_sa);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; flush overrides everything and returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !op[2]) w_state_nxt = op[1] ? ST_DIV : ST_MUL;
         end
         ST_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
            w_state_nxt = ST_COMMIT;
`else
            if (w_last) w_state_nxt = ST_COMMIT;
`endif
         end
         ST_DIV: begin
            if (w_last) w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (flush) w_state_nxt = ST_IDLE;
   end

   // Datapath, HI/LO and the done/div_by_zero pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_is_div <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        r_a      <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_sa     <= w_neg_a;
                        r_sb     <= w_neg_b;
                        r_is_div <= op[1];
                        r_cnt    <= '0;
                        r_acc    <= op[1] ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
                     end
                     OP_MTHI: begin
                        r_hi   <= rs_val;
                        r_done <= 1'b1;
                     end
                     OP_MTLO: begin
                        r_lo   <= rs_val;
                        r_done <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
               r_acc <= {32'd0, r_a} * {32'd0, r_b};
`else
               r_acc <= {w_mul_sum, r_acc[31:1]};
`endif
               r_cnt <= r_cnt + 5'd1;
            end
            ST_DIV: begin
               r_acc <= {w_rem_nxt, r_acc[30:0], w_qbit};
               r_cnt <= r_cnt + 5'd1;
            end
            ST_COMMIT: begin
               if (!flush) begin
                  r_done <= 1'b1;
                  if (!r_is_div) begin
                     r_hi <= w_prod[63:32];
                     r_lo <= w_prod[31:0];
                  end else if (r_b == '0) begin
                     r_hi  <= w_dvd;
                     r_lo  <= '1;
                     r_dbz <= 1'b1;
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hi          = r_hi;
   assign lo          = r_lo;
   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign stall       = hilo_rd & busy;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases with constant
// expectations plus randomized ops against an arithmetic reference model.
// Honours MULDIV_FAST_MULT_EN for the expected multiply latency.
module tb_hilo_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n, start, flush, hilo_rd;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic [31:0] hi, lo;
   logic        busy, done, div_by_zero, stall;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] m_hi, m_lo;

`ifdef MULDIV_FAST_MULT_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   hilo_muldiv_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .hilo_rd(hilo_rd),
      .hi(hi), .lo(lo), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .stall(stall)
   );

   always #5 clk = ~clk;

   function automatic int exp_lat(input logic [2:0] o);
      if (o < 3'd2) return MUL_LAT;
      if (o < 3'd4) return DIV_LAT;
      return 0;
   endfunction

   // Reference: plain 64-bit arithmetic on the architectural definitions.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, b,
                                 inout logic [31:0] h, l, output logic z);
      logic [63:0] p;
      longint sa, sb, q, r;
      z  = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               h = a; l = 32'hFFFF_FFFF; z = 1'b1;
            end else if (o == 3'd2) begin
               q = sa / sb; r = sa % sb;
               p = 64'(q); l = p[31:0];
               p = 64'(r); h = p[31:0];
            end else begin
               l = a / b; h = a % b;
            end
         end
         3'd4: h = a;
         3'd5: l = a;
         default: ;
      endcase
   endfunction

   // Stimulus only: issue one op from a negedge and wait (bounded) for done.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, b,
                         output int lat, output logic [31:0] h, l, output logic z);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      h = hi; l = lo; z = div_by_zero;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; hilo_rd = 1'b1;
      op = '0; rs_val = '0; rt_val = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({hi, lo, busy, done, div_by_zero, stall} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dbz=%b stall=%b, required all 0",
                  hi, lo, busy, done, div_by_zero, stall);
      end
      rst_n = 1'b1; hilo_rd = 1'b0;
      m_hi = '0; m_lo = '0;
      @(negedge clk);
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] a, b, eh, el;
      logic        ez;
   } dcase_t;

   task automatic test_directed();
      dcase_t tbl[8];
      int lat;
      logic [31:0] h, l;
      logic z;
      tbl[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
      tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[3] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
      tbl[5] = '{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
      tbl[6] = '{3'd2, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1};
      tbl[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      foreach (tbl[i]) begin
         run_op(tbl[i].o, tbl[i].a, tbl[i].b, lat, h, l, z);
         n_checks++;
         if (lat !== exp_lat(tbl[i].o)) begin
            n_fail++;
            $display("FAIL directed[%0d] latency: got %0d, required %0d", i, lat, exp_lat(tbl[i].o));
         end
         n_checks++;
         if ({h, l, z} !== {tbl[i].eh, tbl[i].el, tbl[i].ez}) begin
            n_fail++;
            $display("FAIL directed[%0d] result: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                     i, h, l, z, tbl[i].eh, tbl[i].el, tbl[i].ez);
         end
         @(negedge clk);
         n_checks++;
         if ({done, div_by_zero, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL directed[%0d] pulse: done=%b dbz=%b busy=%b a cycle later, required 000",
                     i, done, div_by_zero, busy);
         end
         m_hi = tbl[i].eh; m_lo = tbl[i].el;
      end
   endtask

   task automatic test_stall();
      int n;
      op = 3'd0; rs_val = 32'd9; rt_val = 32'd11; start = 1'b1; hilo_rd = 1'b1;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_start_cycle: stall=%b, required 0", stall);
      end
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({busy, stall} !== 2'b11) begin
         n_fail++;
         $display("FAIL stall_busy: busy=%b stall=%b, required 11", busy, stall);
      end
      hilo_rd = 1'b0;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_no_rd: stall=%b, required 0", stall);
      end
      n = 0;
      while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      n_checks++;
      if ({n, hi, lo} !== {MUL_LAT, 32'd0, 32'd99}) begin
         n_fail++;
         $display("FAIL stall_result: lat=%0d hi=%h lo=%h, required lat=%0d hi=0 lo=63",
                  n, hi, lo, MUL_LAT);
      end
      m_hi = 32'd0; m_lo = 32'd99;
      @(negedge clk);
   endtask

   task automatic test_flush();
      int seen;
      op = 3'd2; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_busy: busy=%b after flush edge, required 0", busy);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen++;
         @(negedge clk);
      end
      n_checks++;
      if ({seen, hi, lo} !== {32'd0, m_hi, m_lo}) begin
         n_fail++;
         $display("FAIL flush_result: dones=%0d hi=%h lo=%h, required 0 dones hi=%h lo=%h",
                  seen, hi, lo, m_hi, m_lo);
      end
      op = 3'd5; rs_val = 32'hA5A5_1234; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      n_checks++;
      if ({done, busy, lo} !== {2'b00, m_lo}) begin
         n_fail++;
         $display("FAIL flush_mtlo: done=%b busy=%b lo=%h, required done=0 busy=0 lo=%h",
                  done, busy, lo, m_lo);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [31:0] h, l;
      logic z;
      run_op(3'd4, 32'h1111_2222, 32'd0, lat, h, l, z);
      run_op(3'd5, 32'h3333_4444, 32'd0, lat, h, l, z);
      n_checks++;
      if ({lat, hi, lo} !== {32'd0, 32'h1111_2222, 32'h3333_4444}) begin
         n_fail++;
         $display("FAIL mt_write: lat=%0d hi=%h lo=%h, required 0 11112222 33334444", lat, hi, lo);
      end
      op = 3'd0; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({hi, lo, busy, done, div_by_zero} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b dbz=%b, required all 0",
                  hi, lo, busy, done, div_by_zero);
      end
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0;
      @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      int cnt, first;
      op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0; first = -1;
      for (int i = 0; i < 60; i++) begin
         if (done === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
         end
         if (i == 3)  begin op = 3'd4; rs_val = 32'hDEAD_BEEF; start = 1'b1; end
         if (i == 4)  start = 1'b0;
         if (i == 10) begin op = 3'd0; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1; end
         if (i == 11) start = 1'b0;
         @(negedge clk);
      end
      n_checks++;
      if ({cnt, first, hi, lo} !== {32'd1, 32'd33, 32'd2, 32'd14}) begin
         n_fail++;
         $display("FAIL busy_ignore: dones=%0d first=%0d hi=%h lo=%h, required 1 33 2 e",
                  cnt, first, hi, lo);
      end
      m_hi = 32'd2; m_lo = 32'd14;
   endtask

   task automatic test_back_to_back();
      int lat0, lat1, lat2;
      logic [31:0] h, l;
      logic z;
      run_op(3'd1, 32'd7, 32'd6, lat0, h, l, z);
      run_op(3'd2, 32'hFFFF_FF9C, 32'd7, lat1, h, l, z);
      n_checks++;
      if ({lat1, h, l} !== {DIV_LAT, 32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
         n_fail++;
         $display("FAIL b2b_div: lat=%0d hi=%h lo=%h, required %0d fffffffe fffffff2",
                  lat1, h, l, DIV_LAT);
      end
      run_op(3'd5, 32'h55, 32'd0, lat2, h, l, z);
      n_checks++;
      if ({lat0, lat2, h, l} !== {MUL_LAT, 32'd0, 32'hFFFF_FFFE, 32'h55}) begin
         n_fail++;
         $display("FAIL b2b_mul_mtlo: lat0=%0d lat2=%0d hi=%h lo=%h, required %0d 0 fffffffe 55",
                  lat0, lat2, h, l, MUL_LAT);
      end
      m_hi = 32'hFFFF_FFFE; m_lo = 32'h55;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b, h, l;
      logic        z, ez;
      int lat, seen;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         if (o >= 3'd6) begin
            op = o; rs_val = a; rt_val = b; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            seen = 0;
            for (int k = 0; k < 3; k++) begin
               if (done === 1'b1 || busy === 1'b1) seen++;
               @(negedge clk);
            end
            n_checks++;
            if ({seen, hi, lo} !== {32'd0, m_hi, m_lo}) begin
               n_fail++;
               $display("FAIL rand[%0d] reserved op %0d: activity=%0d hi=%h lo=%h, required 0 %h %h",
                        i, o, seen, hi, lo, m_hi, m_lo);
            end
         end else begin
            model(o, a, b, m_hi, m_lo, ez);
            run_op(o, a, b, lat, h, l, z);
            n_checks++;
            if ({lat, h, l, z} !== {exp_lat(o), m_hi, m_lo, ez}) begin
               n_fail++;
               $display("FAIL rand[%0d] op %0d a=%h b=%h: lat=%0d hi=%h lo=%h dbz=%b, required lat=%0d hi=%h lo=%h dbz=%b",
                        i, o, a, b, lat, h, l, z, exp_lat(o), m_hi, m_lo, ez);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_stall();
      test_flush();
      test_reset_mid();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
